// File: rtl/matrix_bank_file_pkg.sv
// Shared definitions for the matrix bank: op/type codes, sequencer states
// and a width helper. MATRIX_BANK_TRANSPOSE_EN adds the XPOSE state.
package matrix_bank_file_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'b000,
        OP_WRITE = 3'b001,
        OP_CLEAR = 3'b010,
        OP_COPY  = 3'b011,
        OP_XPOSE = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        TYPE_CELL = 2'b00,
        TYPE_ROW  = 2'b01,
        TYPE_COL  = 2'b10,
        TYPE_BAD  = 2'b11
    } type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
`ifdef MATRIX_BANK_TRANSPOSE_EN
        COPY  = 2'd2,
        XPOSE = 2'd3
`else
        COPY  = 2'd2
`endif
    } seq_state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_bank_file_if.sv
// Request/response bus between the coprocessor controller (master) and
// the matrix bank (slave).
interface matrix_bank_file_if
    import matrix_bank_file_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int CELL_WIDTH   = 32,
    parameter int NUM_MATRICES = 3,
    parameter int ADDR_WIDTH   = width_of(SIZE * SIZE),
    parameter int SEL_WIDTH    = width_of(NUM_MATRICES),
    parameter int WIDTH        = CELL_WIDTH * SIZE
);

    logic                  in_req_valid;
    logic                  out_req_ready;
    logic [2:0]            in_op;
    logic [1:0]            in_type;
    logic [SEL_WIDTH-1:0]  in_select_matrix;
    logic [SEL_WIDTH-1:0]  in_src_matrix;
    logic [ADDR_WIDTH-1:0] in_address;
    logic [WIDTH-1:0]      in_data;
    logic [WIDTH-1:0]      out_data;
    logic                  out_rsp_valid;
    logic                  out_error;
    logic                  out_busy;

    modport master (
        output in_req_valid, in_op, in_type, in_select_matrix, in_src_matrix,
               in_address, in_data,
        input  out_req_ready, out_data, out_rsp_valid, out_error, out_busy
    );

    modport slave (
        input  in_req_valid, in_op, in_type, in_select_matrix, in_src_matrix,
               in_address, in_data,
        output out_req_ready, out_data, out_rsp_valid, out_error, out_busy
    );

endinterface

// File: rtl/matrix_bank_file_seq.sv
// Bulk-operation sequencer: walks rows 0..SIZE-1 for CLEAR/COPY (and XPOSE
// when MATRIX_BANK_TRANSPOSE_EN is defined), one row per cycle, then pulses
// done on the edge it returns to IDLE.
module matrix_bank_file_seq
    import matrix_bank_file_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int SEL_WIDTH = 2,
    parameter int ROW_WIDTH = 2
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 start,
    input  seq_state_e           start_state,
    input  logic [SEL_WIDTH-1:0] start_src,
    input  logic [SEL_WIDTH-1:0] start_dst,
    output seq_state_e           state,
    output logic [ROW_WIDTH-1:0] row,
    output logic [SEL_WIDTH-1:0] src,
    output logic [SEL_WIDTH-1:0] dst,
    output logic                 busy,
    output logic                 wr_en,
    output logic                 done
);

    assign busy  = (state != IDLE);
    assign wr_en = busy;

    // Latch the operation on start, step the row counter, finish at the last row.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state <= IDLE;
            row   <= '0;
            src   <= '0;
            dst   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= start_state;
                        row   <= '0;
                        src   <= start_src;
                        dst   <= start_dst;
                    end
                end
                default: begin
                    if (int'(row) == SIZE - 1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        row <= row + ROW_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/matrix_bank_file.sv
// Matrix bank: NUM_MATRICES square SIZE x SIZE matrices with cell/row/column
// access, range-checked requests and sequenced CLEAR/COPY bulk ops.
// Defining MATRIX_BANK_TRANSPOSE_EN enables op 100 (column i of src -> row i of dst).
module matrix_bank_file
    import matrix_bank_file_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int CELL_WIDTH   = 32,
    parameter int NUM_MATRICES = 3,
    parameter int ADDR_WIDTH   = width_of(SIZE * SIZE),
    parameter int SEL_WIDTH    = width_of(NUM_MATRICES),
    parameter int WIDTH        = CELL_WIDTH * SIZE
) (
    input  logic               in_clk,
    input  logic               in_reset,
    matrix_bank_file_if.slave  bus
);

    localparam int CELLS     = SIZE * SIZE;
    localparam int ROW_WIDTH = width_of(SIZE);

    logic [CELL_WIDTH-1:0] mem [NUM_MATRICES][CELLS];

    logic                 accept;
    logic                 sel_bad;
    logic                 src_bad;
    logic                 addr_bad;
    logic                 req_error;
    logic                 do_read;
    logic                 do_write;
    logic                 seq_start;
    seq_state_e           start_state;
    logic [WIDTH-1:0]     read_word;
    logic [WIDTH-1:0]     rd_data;
    logic                 rsp_q;
    logic                 err_q;

    seq_state_e           seq_state;
    logic [ROW_WIDTH-1:0] seq_row;
    logic [SEL_WIDTH-1:0] seq_src;
    logic [SEL_WIDTH-1:0] seq_dst;
    logic                 seq_busy;
    logic                 seq_wr_en;
    logic                 seq_done;

    // Linear cell index of (row r, column c).
    function automatic logic [ADDR_WIDTH-1:0] idx(input int r, input int c);
        return ADDR_WIDTH'(r * SIZE + c);
    endfunction

    assign accept            = bus.in_req_valid & bus.out_req_ready;
    assign bus.out_req_ready = (seq_state == IDLE);
    assign bus.out_busy      = seq_busy;
    assign bus.out_data      = rd_data;
    assign bus.out_rsp_valid = rsp_q | seq_done;
    assign bus.out_error     = err_q;

    // Decode an accepted request into read/write/bulk start or a rejection.
    always_comb begin
        sel_bad = int'(bus.in_select_matrix) >= NUM_MATRICES;
        src_bad = int'(bus.in_src_matrix) >= NUM_MATRICES;
        case (bus.in_type)
            TYPE_CELL: addr_bad = int'(bus.in_address) >= CELLS;
            TYPE_ROW,
            TYPE_COL:  addr_bad = int'(bus.in_address) >= SIZE;
            default:   addr_bad = 1'b1;
        endcase
        req_error   = 1'b0;
        do_read     = 1'b0;
        do_write    = 1'b0;
        seq_start   = 1'b0;
        start_state = IDLE;
        if (accept) begin
            case (bus.in_op)
                OP_READ: begin
                    if (sel_bad || addr_bad) req_error = 1'b1;
                    else                     do_read   = 1'b1;
                end
                OP_WRITE: begin
                    if (sel_bad || addr_bad) req_error = 1'b1;
                    else                     do_write  = 1'b1;
                end
                OP_CLEAR: begin
                    if (sel_bad) req_error = 1'b1;
                    else begin
                        seq_start   = 1'b1;
                        start_state = CLEAR;
                    end
                end
                OP_COPY: begin
                    if (sel_bad || src_bad) req_error = 1'b1;
                    else begin
                        seq_start   = 1'b1;
                        start_state = COPY;
                    end
                end
                OP_XPOSE: begin
`ifdef MATRIX_BANK_TRANSPOSE_EN
                    if (sel_bad || src_bad ||
                        (bus.in_select_matrix == bus.in_src_matrix)) req_error = 1'b1;
                    else begin
                        seq_start   = 1'b1;
                        start_state = XPOSE;
                    end
`else
                    req_error = 1'b1;
`endif
                end
                default: req_error = 1'b1;
            endcase
        end
    end

    // Gather the addressed cell, row or column of the selected matrix.
    always_comb begin
        read_word = '0;
        case (bus.in_type)
            TYPE_CELL: read_word[CELL_WIDTH-1:0] = mem[bus.in_select_matrix][bus.in_address];
            TYPE_ROW: begin
                for (int j = 0; j < SIZE; j++)
                    read_word[j*CELL_WIDTH +: CELL_WIDTH] =
                        mem[bus.in_select_matrix][idx(int'(bus.in_address), j)];
            end
            TYPE_COL: begin
                for (int j = 0; j < SIZE; j++)
                    read_word[j*CELL_WIDTH +: CELL_WIDTH] =
                        mem[bus.in_select_matrix][idx(j, int'(bus.in_address))];
            end
            default: ;
        endcase
    end

    matrix_bank_file_seq #(
        .SIZE      (SIZE),
        .SEL_WIDTH (SEL_WIDTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_seq (
        .in_clk      (in_clk),
        .in_reset    (in_reset),
        .start       (seq_start),
        .start_state (start_state),
        .start_src   (bus.in_src_matrix),
        .start_dst   (bus.in_select_matrix),
        .state       (seq_state),
        .row         (seq_row),
        .src         (seq_src),
        .dst         (seq_dst),
        .busy        (seq_busy),
        .wr_en       (seq_wr_en),
        .done        (seq_done)
    );

    // Storage: host writes land on the accept edge; bulk ops rewrite one destination row per cycle.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            for (int m = 0; m < NUM_MATRICES; m++)
                for (int c = 0; c < CELLS; c++)
                    mem[m][c] <= '0;
        end else if (do_write) begin
            case (bus.in_type)
                TYPE_CELL: mem[bus.in_select_matrix][bus.in_address] <= bus.in_data[CELL_WIDTH-1:0];
                TYPE_ROW: begin
                    for (int j = 0; j < SIZE; j++)
                        mem[bus.in_select_matrix][idx(int'(bus.in_address), j)] <=
                            bus.in_data[j*CELL_WIDTH +: CELL_WIDTH];
                end
                TYPE_COL: begin
                    for (int j = 0; j < SIZE; j++)
                        mem[bus.in_select_matrix][idx(j, int'(bus.in_address))] <=
                            bus.in_data[j*CELL_WIDTH +: CELL_WIDTH];
                end
                default: ;
            endcase
        end else if (seq_wr_en) begin
            for (int j = 0; j < SIZE; j++) begin
                case (seq_state)
                    CLEAR: mem[seq_dst][idx(int'(seq_row), j)] <= '0;
                    COPY:  mem[seq_dst][idx(int'(seq_row), j)] <= mem[seq_src][idx(int'(seq_row), j)];
`ifdef MATRIX_BANK_TRANSPOSE_EN
                    XPOSE: mem[seq_dst][idx(int'(seq_row), j)] <= mem[seq_src][idx(j, int'(seq_row))];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Registered read data and one-cycle read/error pulses.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            rd_data <= '0;
            rsp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rsp_q <= do_read;
            err_q <= req_error;
            if (do_read) rd_data <= read_word;
        end
    end

endmodule
